// File: rtl/lockstep_alu_cmp_if.sv
// lockstep_alu_cmp_if: operand, handshake, result and fault-status bundle for the lockstep ALU comparator
interface lockstep_alu_cmp_if #(
  parameter int WIDTH = 8,
  parameter int ERR_CNT_W = 8
);
  logic in_valid, in_ready, err_clr;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [1:0] sel1, sel2;
  logic out_valid, carry1, carry2, carry_diff, mismatch, err_sticky;
  logic [WIDTH-1:0] alu_out1, alu_out2, diff;
  logic [ERR_CNT_W-1:0] err_count;
  modport master (
    output in_valid, a0, b0, a1, b1, sel1, sel2, err_clr,
    input  in_ready, out_valid, alu_out1, alu_out2, carry1, carry2, diff, carry_diff,
           mismatch, err_sticky, err_count
  );
  modport slave (
    input  in_valid, a0, b0, a1, b1, sel1, sel2, err_clr,
    output in_ready, out_valid, alu_out1, alu_out2, carry1, carry2, diff, carry_diff,
           mismatch, err_sticky, err_count
  );
endinterface

// File: rtl/lockstep_alu_cmp.sv
// lockstep_alu_cmp: dual-channel lockstep ALU with registered compare and sticky/saturating fault tracking
module lockstep_alu_cmp #(
  parameter int WIDTH = 8,
  parameter int ERR_CNT_W = 8,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  lockstep_alu_cmp_if.slave bus
);
  typedef enum logic {RUN, FAULT} state_t;
  state_t state;
  logic s1_valid, mm, accept;
  logic [WIDTH:0] r1, r2;
  logic [ERR_CNT_W-1:0] cnt_base;
  function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] sel);
    return sel == 2'b00 ? {1'b0, a} + {1'b0, b} :
           sel == 2'b01 ? {a < b, a - b} :
           sel == 2'b10 ? {1'b0, a & b} : {1'b0, a | b};
  endfunction
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.err_sticky = state == FAULT;
  assign bus.in_ready = !(HALT_ON_ERR && bus.err_sticky);
  assign mm = s1_valid && r1 != r2;
  // clear takes effect before a coincident mismatch is recorded
  assign cnt_base = bus.err_clr ? '0 : bus.err_count;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= RUN;
      s1_valid <= 1'b0;
      r1 <= '0;
      r2 <= '0;
      bus.out_valid <= 1'b0;
      bus.mismatch <= 1'b0;
      bus.alu_out1 <= '0;
      bus.alu_out2 <= '0;
      bus.carry1 <= 1'b0;
      bus.carry2 <= 1'b0;
      bus.diff <= '0;
      bus.carry_diff <= 1'b0;
      bus.err_count <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        r1 <= alu(bus.a0, bus.b0, bus.sel1);
        r2 <= alu(bus.a1, bus.b1, bus.sel2);
      end
      bus.out_valid <= s1_valid;
      bus.mismatch <= mm;
      if (s1_valid) begin
        bus.alu_out1 <= r1[WIDTH-1:0];
        bus.alu_out2 <= r2[WIDTH-1:0];
        bus.carry1 <= r1[WIDTH];
        bus.carry2 <= r2[WIDTH];
        bus.diff <= r1[WIDTH-1:0] ^ r2[WIDTH-1:0];
        bus.carry_diff <= r1[WIDTH] ^ r2[WIDTH];
      end
      bus.err_count <= cnt_base + ERR_CNT_W'(mm && !(&cnt_base));
      state <= mm ? FAULT : bus.err_clr ? RUN : state;
    end
endmodule

// File: tb/tb_lockstep_alu_cmp.sv
// tb_lockstep_alu_cmp: directed scoreboard bench; instance a halts on error, instance b uses a 2-bit non-halting counter
module tb_lockstep_alu_cmp;
  typedef struct {
    logic [7:0] o1, o2;
    logic c1, c2;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  lockstep_alu_cmp_if #(.WIDTH(8), .ERR_CNT_W(8)) ia ();
  lockstep_alu_cmp_if #(.WIDTH(8), .ERR_CNT_W(2)) ib ();
  lockstep_alu_cmp #(.WIDTH(8), .ERR_CNT_W(8), .HALT_ON_ERR(1'b1)) dut_a (.wb_clk_i(clk), .wb_rst_i(rst), .bus(ia));
  lockstep_alu_cmp #(.WIDTH(8), .ERR_CNT_W(2), .HALT_ON_ERR(1'b0)) dut_b (.wb_clk_i(clk), .wb_rst_i(rst), .bus(ib));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
    logic [8:0] t;
    case (sel)
      2'b00: t = {1'b0, a} + {1'b0, b};
      2'b01: begin
        t = {1'b0, a} + {1'b0, ~b} + 9'd1;
        t[8] = ~t[8];
      end
      2'b10: t = {1'b0, a & b};
      default: t = {1'b0, a | b};
    endcase
    return t;
  endfunction
  task automatic go(input bit u, input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1,
                    input logic [7:0] b1, input logic [1:0] s1, input logic [1:0] s2);
    exp_t e;
    logic [8:0] m1, m2;
    m1 = model(a0, b0, s1);
    m2 = model(a1, b1, s2);
    e.o1 = m1[7:0];
    e.c1 = m1[8];
    e.o2 = m2[7:0];
    e.c2 = m2[8];
    e.due = cyc + 2;
    if (!u) begin
      ia.in_valid = 1'b1; ia.a0 = a0; ia.b0 = b0; ia.a1 = a1; ia.b1 = b1; ia.sel1 = s1; ia.sel2 = s2;
      if (ia.in_ready) qa.push_back(e);
    end else begin
      ib.in_valid = 1'b1; ib.a0 = a0; ib.b0 = b0; ib.a1 = a1; ib.b1 = b1; ib.sel1 = s1; ib.sel2 = s2;
      if (ib.in_ready) qb.push_back(e);
    end
    @(posedge clk);
    #1;
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (ia.out_valid === 1'b1) begin
      chk("a_ov_expected", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_latency", cyc, ea.due);
        chk("a_out1", ia.alu_out1, ea.o1);
        chk("a_out2", ia.alu_out2, ea.o2);
        chk("a_carry1", ia.carry1, ea.c1);
        chk("a_carry2", ia.carry2, ea.c2);
        chk("a_diff", ia.diff, ea.o1 ^ ea.o2);
        chk("a_carry_diff", ia.carry_diff, ea.c1 ^ ea.c2);
        chk("a_mismatch", ia.mismatch, (ea.o1 != ea.o2) || (ea.c1 != ea.c2));
      end
    end
  always @(negedge clk)
    if (ib.out_valid === 1'b1) begin
      chk("b_ov_expected", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_latency", cyc, eb.due);
        chk("b_out1", ib.alu_out1, eb.o1);
        chk("b_out2", ib.alu_out2, eb.o2);
        chk("b_carry1", ib.carry1, eb.c1);
        chk("b_carry2", ib.carry2, eb.c2);
        chk("b_diff", ib.diff, eb.o1 ^ eb.o2);
        chk("b_mismatch", ib.mismatch, (eb.o1 != eb.o2) || (eb.c1 != eb.c2));
      end
    end
  initial begin
    ia.in_valid = 0; ia.err_clr = 0; ia.a0 = 0; ia.b0 = 0; ia.a1 = 0; ia.b1 = 0; ia.sel1 = 0; ia.sel2 = 0;
    ib.in_valid = 0; ib.err_clr = 0; ib.a0 = 0; ib.b0 = 0; ib.a1 = 0; ib.b1 = 0; ib.sel1 = 0; ib.sel2 = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_err_count", ia.err_count, 0);
    chk("rst_err_sticky", ia.err_sticky, 0);
    chk("rst_in_ready", ia.in_ready, 1);
    chk("rst_out1", ia.alu_out1, 0);
    chk("rst_b_count", ib.err_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    chk("post_rst_in_ready", ia.in_ready, 1);
    // matching ADD with carry out
    go(0, 8'hF0, 8'h20, 8'hF0, 8'h20, 2'b00, 2'b00);
    idle(2);
    chk("add_no_err", ia.err_count, 0);
    // back-to-back matching ops
    go(0, 8'hCC, 8'hAA, 8'hCC, 8'hAA, 2'b10, 2'b10);
    go(0, 8'h0F, 8'h30, 8'h0F, 8'h30, 2'b11, 2'b11);
    go(0, 8'h7F, 8'h01, 8'h7F, 8'h01, 2'b00, 2'b00);
    go(0, 8'h03, 8'h09, 8'h03, 8'h09, 2'b01, 2'b01);
    idle(3);
    chk("b2b_no_err", ia.err_count, 0);
    chk("b2b_sticky", ia.err_sticky, 0);
    // back-to-back with a mismatch on the 3rd; 4th is in flight when halt engages
    go(0, 8'hCC, 8'hAA, 8'hCC, 8'hAA, 2'b10, 2'b10);
    go(0, 8'h0F, 8'h30, 8'h0F, 8'h30, 2'b11, 2'b11);
    go(0, 8'h80, 8'h80, 8'h80, 8'h81, 2'b00, 2'b00);
    go(0, 8'h10, 8'h01, 8'h10, 8'h01, 2'b01, 2'b01);
    idle(3);
    chk("halt_count", ia.err_count, 1);
    chk("halt_sticky", ia.err_sticky, 1);
    chk("halt_in_ready", ia.in_ready, 0);
    go(0, 8'h01, 8'h01, 8'h01, 8'h01, 2'b00, 2'b00);
    idle(3);
    chk("halt_blocked", qa.size(), 0);
    ia.err_clr = 1'b1;
    idle(1);
    ia.err_clr = 1'b0;
    chk("clr_count", ia.err_count, 0);
    chk("clr_sticky", ia.err_sticky, 0);
    chk("clr_in_ready", ia.in_ready, 1);
    // divergent SUB: 5-7 vs 5-6
    go(0, 8'd5, 8'd7, 8'd5, 8'd6, 2'b01, 2'b01);
    idle(1);
    chk("sub_mismatch", ia.mismatch, 1);
    chk("sub_diff", ia.diff, 8'h01);
    chk("sub_count", ia.err_count, 1);
    chk("sub_sticky", ia.err_sticky, 1);
    chk("sub_in_ready", ia.in_ready, 0);
    ia.err_clr = 1'b1;
    idle(1);
    ia.err_clr = 1'b0;
    // saturation on the 2-bit counter, select disagreement included
    for (int i = 0; i < 5; i++) begin
      if (i == 4) go(1, 8'h06, 8'h03, 8'h06, 8'h03, 2'b00, 2'b01);
      else go(1, 8'h10, 8'h01, 8'h10, 8'h02, 2'b01, 2'b01);
      idle(1);
      chk("sat_count", ib.err_count, i < 2 ? i + 1 : 3);
      chk("sat_in_ready", ib.in_ready, 1);
    end
    // clear colliding with a mismatch
    go(1, 8'h22, 8'h11, 8'h22, 8'h12, 2'b00, 2'b00);
    ib.err_clr = 1'b1;
    idle(1);
    ib.err_clr = 1'b0;
    chk("coll_count", ib.err_count, 1);
    chk("coll_sticky", ib.err_sticky, 1);
    ib.err_clr = 1'b1;
    idle(1);
    ib.err_clr = 1'b0;
    chk("clr2_count", ib.err_count, 0);
    chk("clr2_sticky", ib.err_sticky, 0);
    chk("clr2_in_ready", ib.in_ready, 1);
    // async reset with operations in flight
    go(0, 8'h01, 8'h01, 8'h01, 8'h02, 2'b00, 2'b00);
    go(0, 8'h03, 8'h04, 8'h03, 8'h04, 2'b00, 2'b00);
    chk("pre_rst_count", ia.err_count, 1);
    #1 rst = 1'b1;
    qa.delete();
    #1;
    chk("arst_out_valid", ia.out_valid, 0);
    chk("arst_count", ia.err_count, 0);
    chk("arst_sticky", ia.err_sticky, 0);
    chk("arst_in_ready", ia.in_ready, 1);
    chk("arst_out1", ia.alu_out1, 0);
    chk("arst_out2", ia.alu_out2, 0);
    chk("arst_diff", ia.diff, 0);
    chk("arst_mismatch", ia.mismatch, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(4);
    chk("post_arst_in_ready", ia.in_ready, 1);
    chk("a_drained", qa.size(), 0);
    chk("b_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
